// File: rtl/parallel_to_serial_tx.sv
// Parallel-to-serial transmitter. An 8-bit word from SW[7:0] is loaded by a
// debounced button press and sent LSB first on LEDR[0]. Each bit is advanced
// by a button press, or by a fixed-period tick when SW[9] selects auto mode.
module parallel_to_serial_tx #(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int STEP_CYCLES     = 125000000
) (
  input  logic       CLOCK_125_p,
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  output logic [7:0] LEDG,
  output logic [7:0] LEDR,
  output logic [6:0] HEX0
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (STEP_CYCLES > 1)     ? $clog2(STEP_CYCLES)     : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  logic          w_rst_n;
  logic          w_unused;
  logic [1:0]    r_sync;      // [0] first flop, [1] synchronized button level
  logic [1:0]    r_vld_pipe;  // marks when r_sync holds real samples, not reset values
  logic          r_db_level;  // debounced level, 1 = released
  logic [DW-1:0] r_db_cnt;
  logic          r_armed;     // set once a release has been seen since reset
  logic          r_press;     // one-cycle press event
  logic          r_auto;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [2:0]    r_bitcnt, w_bitcnt_nxt;
  logic [TW-1:0] r_tick, w_tick_nxt;
  logic          w_tick_hit;
  logic          w_step;

  assign w_rst_n  = KEY[0];
  assign w_unused = SW[8];

  // Synchronize, debounce and edge-detect the step button.
  always_ff @(posedge CLOCK_125_p or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync     <= 2'b11;
      r_vld_pipe <= 2'b00;
      r_db_level <= 1'b1;
      r_db_cnt   <= '0;
      r_armed    <= 1'b0;
      r_press    <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], KEY[1]};
      r_vld_pipe <= {r_vld_pipe[0], 1'b1};
      r_press    <= 1'b0;
      if (!r_vld_pipe[1]) begin
        r_db_cnt <= '0;
      end else if (r_sync[1] != r_db_level) begin
        if (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_db_level <= r_sync[1];
          r_db_cnt   <= '0;
          // Falling debounced level is a press; suppressed if the button was
          // already down when reset released.
          r_press    <= r_db_level & r_armed;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
      if (r_vld_pipe[1] && r_db_level && r_sync[1]) r_armed <= 1'b1;
    end
  end

  // Register the auto-mode switch so it acts from the next cycle.
  always_ff @(posedge CLOCK_125_p or negedge w_rst_n) begin
    if (!w_rst_n) r_auto <= 1'b0;
    else          r_auto <= SW[9];
  end

  // State and datapath registers.
  always_ff @(posedge CLOCK_125_p or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_tick   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_tick   <= w_tick_nxt;
    end
  end

  assign w_tick_hit = (r_tick == TW'(STEP_CYCLES - 1));

  // Next-state: load on press from IDLE/DONE, step through bits in SHIFT.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_tick_nxt   = '0;
    w_step       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_press) begin
          w_state_nxt  = S_SHIFT;
          w_shift_nxt  = SW[7:0];
          w_bitcnt_nxt = '0;
        end
      end
      S_SHIFT: begin
        if (r_auto) begin
          w_step     = w_tick_hit;
          w_tick_nxt = w_tick_hit ? '0 : r_tick + 1'b1;
        end else begin
          w_step = r_press;
        end
        if (w_step) begin
          if (r_bitcnt == 3'd7) begin
            w_state_nxt = S_DONE;
          end else begin
            w_shift_nxt  = {1'b0, r_shift[7:1]};
            w_bitcnt_nxt = r_bitcnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  function automatic logic [6:0] f_hex(input logic [2:0] d);
    case (d)
      3'd0: f_hex = 7'b1000000;
      3'd1: f_hex = 7'b1111001;
      3'd2: f_hex = 7'b0100100;
      3'd3: f_hex = 7'b0110000;
      3'd4: f_hex = 7'b0011001;
      3'd5: f_hex = 7'b0010010;
      3'd6: f_hex = 7'b0000010;
      default: f_hex = 7'b1111000;
    endcase
  endfunction

  // Outputs decoded only from registered state.
  always_comb begin
    LEDG = r_shift;
    LEDR = '0;
    HEX0 = 7'b1111111;
    case (r_state)
      S_SHIFT: begin
        LEDR[0] = r_shift[0];
        LEDR[1] = 1'b1;
        HEX0    = f_hex(r_bitcnt);
      end
      S_DONE: begin
        LEDR[2] = 1'b1;
        HEX0    = 7'b0111111;
      end
      default: ;
    endcase
  end

endmodule
